// File: rtl/i2s_dac_serializer.sv
// I2S DAC serializer: one-pair holding buffer feeding a BCLK/LRCK-slaved shifter.
// Optional build macro DAC_MUTE_ON_UNDERRUN_EN: an underrun frame transmits zeros instead of repeating the last pair.
module i2s_dac_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_BITS   = 24,
  parameter int CNT_W      = 6
) (
  input  logic                  AUD_BCLK,
  input  logic                  reset,
  input  logic                  AUD_DACLRCK,
  input  logic [DATA_WIDTH-1:0] left_channel_audio_in,
  input  logic [DATA_WIDTH-1:0] right_channel_audio_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  AUD_DACDAT,
  output logic                  underrun
);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t              state, state_nxt;
  logic                lrck_d;
  logic                fall_edge, rise_edge;
  logic                accept;
  logic                hold_empty;
  logic [OUT_BITS-1:0] hold_l, hold_r;
  logic [OUT_BITS-1:0] act_l, act_r, act_l_nxt, act_r_nxt;
  logic [OUT_BITS-1:0] shreg, shreg_shift, load_word;
  logic [CNT_W-1:0]    bit_cnt;
  logic                load_slot;

  // Only the transmitted top OUT_BITS of each sample are ever stored.
  generate
    if (OUT_BITS < DATA_WIDTH) begin : g_trunc
      logic unused_low_bits;
      assign unused_low_bits = ^{left_channel_audio_in[DATA_WIDTH-OUT_BITS-1:0],
                                 right_channel_audio_in[DATA_WIDTH-OUT_BITS-1:0]};
    end
  endgenerate

  assign fall_edge    = lrck_d & ~AUD_DACLRCK;
  assign rise_edge    = ~lrck_d & AUD_DACLRCK;
  assign accept       = sample_valid & hold_empty;
  assign sample_ready = hold_empty;
  assign shreg_shift  = shreg << 1;

  // Active pair for the frame: taken from holding at the left-slot start if one is waiting.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    act_l_nxt = act_l;
    act_r_nxt = act_r;
    if (fall_edge) begin
      if (!hold_empty) begin
        act_l_nxt = hold_l;
        act_r_nxt = hold_r;
      end
`ifdef DAC_MUTE_ON_UNDERRUN_EN
      else begin
        act_l_nxt = '0;
        act_r_nxt = '0;
      end
`endif
    end
  end

  // Slot sequencing: a rise in IDLE is ignored so output always starts on a full frame.
  always_comb begin
    state_nxt = state;
    load_slot = 1'b0;
    load_word = act_r_nxt;
    unique case (state)
      IDLE: begin
        if (fall_edge) begin
          state_nxt = LEFT;
          load_slot = 1'b1;
          load_word = act_l_nxt;
        end
      end
      LEFT: begin
        if (fall_edge) begin
          load_slot = 1'b1;
          load_word = act_l_nxt;
        end else if (rise_edge) begin
          state_nxt = RIGHT;
          load_slot = 1'b1;
          load_word = act_r_nxt;
        end
      end
      RIGHT: begin
        if (fall_edge) begin
          state_nxt = LEFT;
          load_slot = 1'b1;
          load_word = act_l_nxt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AUD_BCLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge AUD_BCLK or negedge reset) begin
    // NOTE: the sample buffers are reset too, so a post-reset underrun replays zeros rather than stale audio.
    if (!reset) begin
      lrck_d     <= 1'b1;
      hold_empty <= 1'b1;
      hold_l     <= '0;
      hold_r     <= '0;
      act_l      <= '0;
      act_r      <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      AUD_DACDAT <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      lrck_d   <= AUD_DACLRCK;
      underrun <= fall_edge & hold_empty;
      act_l    <= act_l_nxt;
      act_r    <= act_r_nxt;

      // An accept coinciding with an empty-buffer frame start keeps the new pair for the next frame.
      if (accept) begin
        hold_l     <= left_channel_audio_in[DATA_WIDTH-1 -: OUT_BITS];
        hold_r     <= right_channel_audio_in[DATA_WIDTH-1 -: OUT_BITS];
        hold_empty <= 1'b0;
      end else if (fall_edge) begin
        hold_empty <= 1'b1;
      end

      if (load_slot) begin
        shreg      <= load_word;
        AUD_DACDAT <= load_word[OUT_BITS-1];
        bit_cnt    <= CNT_W'(1);
      end else if (state == IDLE) begin
        AUD_DACDAT <= 1'b0;
      end else if (bit_cnt < CNT_W'(OUT_BITS)) begin
        shreg      <= shreg_shift;
        AUD_DACDAT <= shreg_shift[OUT_BITS-1];
        bit_cnt    <= bit_cnt + 1'b1;
      end else begin
        AUD_DACDAT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Directed bench for i2s_dac_serializer: frame alignment, handshake, underrun, short slot, mid-slot reset.
module tb_i2s_dac_serializer;

`ifdef DAC_MUTE_ON_UNDERRUN_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic        AUD_BCLK = 1'b0;
  logic        reset;
  logic        AUD_DACLRCK;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        AUD_DACDAT;
  logic        underrun;

  i2s_dac_serializer #(.DATA_WIDTH(32), .OUT_BITS(24), .CNT_W(6)) dut (
    .AUD_BCLK               (AUD_BCLK),
    .reset                  (reset),
    .AUD_DACLRCK            (AUD_DACLRCK),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
    .sample_valid           (sample_valid),
    .sample_ready           (sample_ready),
    .AUD_DACDAT             (AUD_DACDAT),
    .underrun               (underrun)
  );

  always #5 AUD_BCLK = ~AUD_BCLK;

  int          tests = 0;
  int          failed = 0;
  logic [31:0] pl [0:7];
  logic [31:0] pr [0:7];
  int          prod_idx = 0;
  int          prod_n = 0;
  logic        accept_pending = 1'b0;
  logic        rst_next = 1'b0;
  logic        pend_valid = 1'b0;
  logic        pend_bit = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] top24(input logic [31:0] v);
    return v[31:8];
  endfunction

  function automatic logic exp_bit(input logic [23:0] bits, input int j);
    if (j < 24) return bits[23-j];
    return 1'b0;
  endfunction

  // One BCLK: advance the producer past an accepted pair, drive inputs after the falling edge.
  task automatic cyc(input logic lv);
    @(negedge AUD_BCLK);
    if (accept_pending) prod_idx++;
    reset       = rst_next;
    AUD_DACLRCK = lv;
    if (prod_idx < prod_n) begin
      sample_valid           = 1'b1;
      left_channel_audio_in  = pl[prod_idx];
      right_channel_audio_in = pr[prod_idx];
    end else begin
      sample_valid           = 1'b0;
      left_channel_audio_in  = '0;
      right_channel_audio_in = '0;
    end
    #1;
    accept_pending = sample_valid && sample_ready && reset;
  endtask

  task automatic run_slot(input string name, input logic lv, input int n, input logic [23:0] bits,
                          input logic exp_ur, input logic exp_r1, input logic exp_r2);
    for (int i = 0; i < n; i++) begin
      cyc(lv);
      if (i == 0) begin
        if (pend_valid) chk($sformatf("%s prev_slot_tail", name), AUD_DACDAT, pend_bit);
      end else begin
        chk($sformatf("%s dac_bit%0d", name, i - 1), AUD_DACDAT, exp_bit(bits, i - 1));
      end
      if (i == 1) begin
        chk($sformatf("%s underrun_start", name), underrun, exp_ur);
        chk($sformatf("%s ready_1", name), sample_ready, exp_r1);
      end
      if (i == 2) begin
        chk($sformatf("%s underrun_clear", name), underrun, 1'b0);
        chk($sformatf("%s ready_2", name), sample_ready, exp_r2);
      end
    end
    pend_valid = 1'b1;
    pend_bit   = exp_bit(bits, n - 1);
  endtask

  logic [23:0] ul, ur, yl;

  initial begin
    reset                  = 1'b0;
    AUD_DACLRCK            = 1'b1;
    sample_valid           = 1'b0;
    left_channel_audio_in  = '0;
    right_channel_audio_in = '0;

    pl[0] = 32'hA5A5_0000; pr[0] = 32'h0F0F_0000;
    for (int k = 0; k < 4; k++) begin
      pl[k+1] = 32'hC03C_5AFF + (32'(k) << 24);
      pr[k+1] = 32'h2081_7E00 + (32'(k) << 24);
    end
    pl[5] = 32'h8000_0000; pr[5] = 32'h4000_0000;
    pl[6] = 32'hDEAD_BEEF; pr[6] = 32'h1234_5678;
    pl[7] = 32'h0123_4567; pr[7] = 32'hFEDC_BA98;
    prod_n = 6;

    ul = MUTE ? 24'h000000 : 24'h800000;
    ur = MUTE ? 24'h000000 : 24'h400000;
    yl = MUTE ? 24'h000000 : 24'hDEADBE;

    // Reset held with a pair offered: nothing accepted, outputs quiet.
    rst_next = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      chk("rst dac", AUD_DACDAT, 1'b0);
      chk("rst ready", sample_ready, 1'b1);
      chk("rst underrun", underrun, 1'b0);
    end
    rst_next = 1'b1;
    cyc(1'b1);
    chk("release ready", sample_ready, 1'b1);
    cyc(1'b1);
    chk("accept drops ready", sample_ready, 1'b0);
    chk("idle dac", AUD_DACDAT, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1);
      chk("idle dac", AUD_DACDAT, 1'b0);
      chk("idle underrun", underrun, 1'b0);
    end

    // First frame plus four streamed frames, one accept per frame, no underrun.
    run_slot("fA_L", 1'b0, 32, 24'hA5A500, 1'b0, 1'b1, 1'b0);
    run_slot("fA_R", 1'b1, 32, 24'h0F0F00, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      run_slot($sformatf("fP%0d_L", k - 1), 1'b0, 32, top24(pl[k]), 1'b0, 1'b1, 1'b0);
      run_slot($sformatf("fP%0d_R", k - 1), 1'b1, 32, top24(pr[k]), 1'b0, 1'b0, 1'b0);
    end
    run_slot("fX_L", 1'b0, 32, 24'h800000, 1'b0, 1'b1, 1'b1);
    run_slot("fX_R", 1'b1, 32, 24'h400000, 1'b0, 1'b1, 1'b1);

    // Underrun frame: repeat or mute depending on build.
    run_slot("fU_L", 1'b0, 32, ul, 1'b1, 1'b1, 1'b1);
    run_slot("fU_R", 1'b1, 32, ur, 1'b0, 1'b1, 1'b1);

    // Pair offered exactly at the frame start with the buffer empty.
    prod_n = 7;
    run_slot("fU2_L", 1'b0, 32, ul, 1'b1, 1'b0, 1'b0);
    run_slot("fU2_R", 1'b1, 32, ur, 1'b0, 1'b0, 1'b0);

    // Short 16-BCLK left slot truncates; right slot starts clean.
    run_slot("fY_L", 1'b0, 16, 24'hDEADBE, 1'b0, 1'b1, 1'b1);
    run_slot("fY_R", 1'b1, 32, 24'h123456, 1'b0, 1'b1, 1'b1);

    // Reset mid-slot, release in the right slot, then re-align on the next fall.
    run_slot("fR_L", 1'b0, 10, yl, 1'b1, 1'b1, 1'b1);
    pend_valid = 1'b0;
    rst_next   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(i < 2 ? 1'b0 : 1'b1);
      chk("midrst dac", AUD_DACDAT, 1'b0);
      chk("midrst ready", sample_ready, 1'b1);
      chk("midrst underrun", underrun, 1'b0);
    end
    prod_n   = 8;
    rst_next = 1'b1;
    cyc(1'b1);
    chk("rerelease ready", sample_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("post_rst dac", AUD_DACDAT, 1'b0);
      chk("post_rst underrun", underrun, 1'b0);
      chk("post_rst ready", sample_ready, 1'b0);
    end
    run_slot("fZ_L", 1'b0, 32, 24'h012345, 1'b0, 1'b1, 1'b1);
    run_slot("fZ_R", 1'b1, 32, 24'hFEDCBA, 1'b0, 1'b1, 1'b1);
    cyc(1'b1);
    chk("fZ_R tail", AUD_DACDAT, pend_bit);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
